irq_ctrl: RTL and testbench

- Interrupt controller: receiving end of the SoC external interrupt lines (i_ext[30:0]). Presents one prioritised request plus vector to the CPU core.
- Synchronises each line and detects its rising edge. Latches one pending bit per source and applies a software mask.
- Runs an request/acknowledge/return-from-interrupt handshake with the core. Only one interrupt is in service at a time (no nesting).

---
 rtl/irq_ctrl.sv | 136 +++++++++++++
 tb/tb_irq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Prioritised external interrupt controller: sync + rising-edge detect, pending/mask, req/ack/reti handshake.
// Optional build macro IRQ_OVERRUN_EN adds sticky per-source overrun flags (o_overrun, i_ovr_clr).
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | nothing in flight; pick lowest eligible source when one appears
// ST_REQ     | o_irq_req high, vector frozen, waiting for i_irq_ack
// ST_SERVICE | core is running the handler (o_busy), waiting for i_reti
module irq_ctrl #(
  parameter int N_SRC = 31,
  parameter int VEC_W = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_SRC-1:0] i_ext,
  input  logic             i_mask_we,
  input  logic [N_SRC-1:0] i_mask_data,
  output logic [N_SRC-1:0] o_mask,
  output logic [N_SRC-1:0] o_pending,
  output logic             o_irq_req,
  output logic [VEC_W-1:0] o_irq_vec,
  input  logic             i_irq_ack,
  input  logic             i_reti,
  output logic             o_busy
`ifdef IRQ_OVERRUN_EN
  ,
  input  logic             i_ovr_clr,
  output logic [N_SRC-1:0] o_overrun
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] rise, elig, clr;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic [VEC_W-1:0] vec_q, vec_d, low_idx;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      vec_q   <= '0;
    end else begin
      sync1_q <= i_ext;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      vec_q   <= vec_d;
    end
  end

  // Descending scan so the last hit, i.e. the lowest index, wins.
  always_comb begin
    rise    = sync2_q & ~prev_q;
    elig    = pend_q & mask_q;
    low_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) low_idx = VEC_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    busy_d  = busy_q;
    vec_d   = vec_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (elig != '0) begin
          vec_d   = low_idx;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_irq_ack) begin
          clr     = {{(N_SRC-1){1'b0}}, 1'b1} << vec_q;
          req_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (i_reti) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A new edge on the bit being acknowledged must survive the clear.
  assign pend_d = (pend_q & ~clr) | rise;
  assign mask_d = i_mask_we ? i_mask_data : mask_q;

  assign o_mask    = mask_q;
  assign o_pending = pend_q;
  assign o_irq_req = req_q;
  assign o_irq_vec = vec_q;
  assign o_busy    = busy_q;

`ifdef IRQ_OVERRUN_EN
  logic [N_SRC-1:0] ovr_q, ovr_d;

  assign ovr_d = (ovr_q & ~{N_SRC{i_ovr_clr}}) | (rise & pend_q);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) ovr_q <= '0;
    else      ovr_q <= ovr_d;
  end

  assign o_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: vector table, directed corner sequences, and random
// traffic against a cycle-level behavioural model.
module tb_irq_ctrl;
  localparam int N  = 31;
  localparam int VW = 5;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic [N-1:0]  i_ext = '0;
  logic          i_mask_we = 1'b0;
  logic [N-1:0]  i_mask_data = '0;
  logic          i_irq_ack = 1'b0;
  logic          i_reti = 1'b0;
  logic [N-1:0]  o_mask, o_pending;
  logic          o_irq_req, o_busy;
  logic [VW-1:0] o_irq_vec;
`ifdef IRQ_OVERRUN_EN
  logic          i_ovr_clr = 1'b0;
  logic [N-1:0]  o_overrun;
`endif

  irq_ctrl #(.N_SRC(N), .VEC_W(VW)) dut (
    .Clk(Clk), .Rst(Rst), .i_ext(i_ext),
    .i_mask_we(i_mask_we), .i_mask_data(i_mask_data),
    .o_mask(o_mask), .o_pending(o_pending),
    .o_irq_req(o_irq_req), .o_irq_vec(o_irq_vec),
    .i_irq_ack(i_irq_ack), .i_reti(i_reti), .o_busy(o_busy)
`ifdef IRQ_OVERRUN_EN
    , .i_ovr_clr(i_ovr_clr), .o_overrun(o_overrun)
`endif
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: x history of sampled lines; an event is a 0->1 between the samples 3 and 2 edges back.
  logic [N-1:0]  h0, h1, h2, m_pend, m_mask, m_ovr;
  int            m_phase;  // 0 waiting, 1 requesting, 2 in service
  logic          m_req, m_busy;
  logic [VW-1:0] m_vec;

  task automatic model_reset();
    h0 = '0; h1 = '0; h2 = '0;
    m_pend = '0; m_mask = '1; m_ovr = '0;
    m_phase = 0; m_req = 1'b0; m_busy = 1'b0; m_vec = '0;
  endtask

  task automatic model_clock(input logic [N-1:0] ext, input logic we, input logic [N-1:0] md,
                             input logic ack, input logic reti, input logic oc);
    logic [N-1:0] ev, clr;
    ev  = h1 & ~h2;
    clr = '0;
    if (m_phase == 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i] && m_mask[i]) begin
          m_vec = VW'(i);
          m_req = 1'b1;
          m_phase = 1;
          break;
        end
      end
    end else if (m_phase == 1) begin
      if (ack) begin
        clr[m_vec] = 1'b1;
        m_req = 1'b0;
        m_busy = 1'b1;
        m_phase = 2;
      end
    end else if (reti) begin
      m_busy = 1'b0;
      m_phase = 0;
    end
    m_ovr  = (oc ? '0 : m_ovr) | (ev & m_pend);
    m_pend = (m_pend & ~clr) | ev;
    if (we) m_mask = md;
    h2 = h1; h1 = h0; h0 = ext;
  endtask

  task automatic step(input logic [N-1:0] ext, input logic we, input logic [N-1:0] md,
                      input logic ack, input logic reti, input logic oc);
    i_ext = ext; i_mask_we = we; i_mask_data = md; i_irq_ack = ack; i_reti = reti;
`ifdef IRQ_OVERRUN_EN
    i_ovr_clr = oc;
`endif
    @(posedge Clk);
    model_clock(ext, we, md, ack, reti, oc);
    @(negedge Clk);
    chk("model_pending", 32'(o_pending), 32'(m_pend));
    chk("model_mask",    32'(o_mask),    32'(m_mask));
    chk("model_req",     32'(o_irq_req), 32'(m_req));
    chk("model_vec",     32'(o_irq_vec), 32'(m_vec));
    chk("model_busy",    32'(o_busy),    32'(m_busy));
`ifdef IRQ_OVERRUN_EN
    chk("model_overrun", 32'(o_overrun), 32'(m_ovr));
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic [N-1:0] bits);
    step(bits, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(bits, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack();
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic reti();
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [N-1:0]  ext;
    logic          ack;
    logic          reti;
    logic [N-1:0]  pend;
    logic          req;
    logic [VW-1:0] vec;
    logic          busy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [N-1:0] ext_r;

    tbl[0] = '{ext: 31'h2, ack: 0, reti: 0, pend: 31'h0, req: 0, vec: 0, busy: 0};
    tbl[1] = '{ext: 31'h2, ack: 0, reti: 0, pend: 31'h0, req: 0, vec: 0, busy: 0};
    tbl[2] = '{ext: 31'h0, ack: 0, reti: 0, pend: 31'h2, req: 0, vec: 0, busy: 0};
    tbl[3] = '{ext: 31'h0, ack: 0, reti: 0, pend: 31'h2, req: 1, vec: 1, busy: 0};
    tbl[4] = '{ext: 31'h0, ack: 0, reti: 0, pend: 31'h2, req: 1, vec: 1, busy: 0};
    tbl[5] = '{ext: 31'h0, ack: 1, reti: 0, pend: 31'h0, req: 0, vec: 1, busy: 1};
    tbl[6] = '{ext: 31'h0, ack: 0, reti: 0, pend: 31'h0, req: 0, vec: 1, busy: 1};
    tbl[7] = '{ext: 31'h0, ack: 0, reti: 1, pend: 31'h0, req: 0, vec: 1, busy: 0};
    tbl[8] = '{ext: 31'h0, ack: 0, reti: 0, pend: 31'h0, req: 0, vec: 1, busy: 0};

    model_reset();
    #12;
    chk("rst_req",     32'(o_irq_req), 32'h0);
    chk("rst_pending", 32'(o_pending), 32'h0);
    chk("rst_mask",    32'(o_mask),    32'h7FFF_FFFF);
    chk("rst_busy",    32'(o_busy),    32'h0);
    chk("rst_vec",     32'(o_irq_vec), 32'h0);
    @(negedge Clk);
    Rst = 1'b1;

    // Basic single interrupt, cycle by cycle
    for (int r = 0; r < 9; r++) begin
      step(tbl[r].ext, 1'b0, '0, tbl[r].ack, tbl[r].reti, 1'b0);
      chk("tbl_pending", 32'(o_pending), 32'(tbl[r].pend));
      chk("tbl_req",     32'(o_irq_req), 32'(tbl[r].req));
      chk("tbl_vec",     32'(o_irq_vec), 32'(tbl[r].vec));
      chk("tbl_busy",    32'(o_busy),    32'(tbl[r].busy));
    end

    // Two events on source 1 before ack merge into one service
    pulse(31'h2); idle(2);
    chk("dbl_req1", 32'(o_irq_req), 32'h1);
    chk("dbl_vec1", 32'(o_irq_vec), 32'h1);
    pulse(31'h2); idle(3);
    chk("dbl_pending", 32'(o_pending), 32'h2);
    chk("dbl_vec2",    32'(o_irq_vec), 32'h1);
`ifdef IRQ_OVERRUN_EN
    chk("dbl_overrun", 32'(o_overrun), 32'h2);
`endif
    ack();
    chk("dbl_ack_pending", 32'(o_pending), 32'h0);
    chk("dbl_ack_busy",    32'(o_busy),    32'h1);
    idle(1); reti(); idle(3);
    chk("dbl_no_second", 32'(o_irq_req), 32'h0);
    step('0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
`ifdef IRQ_OVERRUN_EN
    chk("ovr_clear", 32'(o_overrun), 32'h0);
`endif

    // Re-trigger of the in-service source is delivered after reti
    pulse(31'h2); idle(2); ack();
    pulse(31'h2); idle(2);
    chk("svc_pending", 32'(o_pending), 32'h2);
    chk("svc_req",     32'(o_irq_req), 32'h0);
    reti();
    chk("svc_reti_req", 32'(o_irq_req), 32'h0);
    idle(1);
    chk("svc_rereq",     32'(o_irq_req), 32'h1);
    chk("svc_rereq_vec", 32'(o_irq_vec), 32'h1);
    ack(); reti();

    // Simultaneous 5 and 2: lowest index first
    pulse(31'h24); idle(2);
    chk("pri_vec2", 32'(o_irq_vec), 32'h2);
    chk("pri_pend", 32'(o_pending), 32'h24);
    ack(); reti(); idle(1);
    chk("pri_req5", 32'(o_irq_req), 32'h1);
    chk("pri_vec5", 32'(o_irq_vec), 32'h5);
    ack(); reti();

    // Masked source latches pending, delivered when unmasked
    step('0, 1'b1, 31'h7FFF_FFFB, 1'b0, 1'b0, 1'b0);
    pulse(31'h4); idle(3);
    chk("msk_pending", 32'(o_pending), 32'h4);
    chk("msk_noreq",   32'(o_irq_req), 32'h0);
    step('0, 1'b1, 31'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("msk_req", 32'(o_irq_req), 32'h1);
    chk("msk_vec", 32'(o_irq_vec), 32'h2);
    ack(); reti();

    // Async reset while requesting vector 3
    pulse(31'h8); idle(2);
    chk("rr_req", 32'(o_irq_req), 32'h1);
    chk("rr_vec", 32'(o_irq_vec), 32'h3);
    #2 Rst = 1'b0;
    #1;
    chk("rr_rst_req",     32'(o_irq_req), 32'h0);
    chk("rr_rst_pending", 32'(o_pending), 32'h0);
    chk("rr_rst_mask",    32'(o_mask),    32'h7FFF_FFFF);
    chk("rr_rst_vec",     32'(o_irq_vec), 32'h0);
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    idle(5);
    chk("rr_after_req", 32'(o_irq_req), 32'h0);

    // Random traffic against the model
    ext_r = '0;
    for (int c = 0; c < 3000; c++) begin
      ext_r = ext_r ^ N'($urandom & $urandom & $urandom);
      step(ext_r, ($urandom_range(0, 9) == 0), N'($urandom | $urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
